// File: rtl/crypto_operand_loader.sv
// crypto_operand_loader: host word assembler plus block FIFO for the crypto core.
// Four 32-bit host words (least-significant first) form one 128-bit operand that
// is queued in a FIFO_DEPTH-entry circular buffer and handed to the core with a
// valid/ready handshake.
// Optional build macro: LOADER_BYTESWAP_EN byte-reverses each word before storage.
module crypto_operand_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             Master_clk,
  input  logic             Master_reset,
  input  logic             flush,
  input  logic [31:0]      word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic [127:0]     blk_data,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic [1:0]       word_idx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    W2 = 2'd2,
    W3 = 2'd3
  } asmState_e;

  asmState_e        state_q, state_d;
  logic [95:0]      asmWords_q, asmWords_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     mem_q [FIFO_DEPTH];

  logic [31:0] laneWord;
  logic        accept;
  logic        push;
  logic        pop;

  // Lane formatting of the incoming word; big-endian hosts need bytes reversed.
`ifdef LOADER_BYTESWAP_EN
  assign laneWord = {word_in[7:0], word_in[15:8], word_in[23:16], word_in[31:24]};
`else
  assign laneWord = word_in;
`endif

  // Handshake decodes; ready/valid come from registered occupancy only, and
  // flush suppresses every state-changing event in its cycle.
  assign word_ready = (cnt_q != CNT_W'(FIFO_DEPTH));
  assign blk_valid  = (cnt_q != '0);
  assign accept     = word_valid && word_ready && !flush;
  assign push       = accept && (state_q == W3);
  assign pop        = blk_valid && blk_ready && !flush;

  assign blk_data   = mem_q[rdPtr_q];
  assign fifo_count = cnt_q;
  assign word_idx   = state_q;

  // Assembler next state: park the first three words, wrap to W0 after the fourth.
  always_comb begin
    state_d    = state_q;
    asmWords_d = asmWords_q;
    if (flush) begin
      state_d = W0;
    end else if (accept) begin
      case (state_q)
        W0: begin
          asmWords_d[31:0] = laneWord;
          state_d          = W1;
        end
        W1: begin
          asmWords_d[63:32] = laneWord;
          state_d           = W2;
        end
        W2: begin
          asmWords_d[95:64] = laneWord;
          state_d           = W3;
        end
        W3: begin
          state_d = W0;
        end
        default: state_d = W0;
      endcase
    end
  end

  // FIFO pointer and occupancy next state; simultaneous push and pop leave the count alone.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      cnt_d   = '0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Control state register with asynchronous active-low clear.
  always_ff @(posedge Master_clk or negedge Master_reset) begin
    if (!Master_reset) begin
      state_q    <= W0;
      asmWords_q <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      asmWords_q <= asmWords_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Operand storage is never reset; the completed operand lands at the tail on the W3 accept.
  always_ff @(posedge Master_clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= {laneWord, asmWords_q};
    end
  end

endmodule

// File: tb/tb_crypto_operand_loader.sv
// tb_crypto_operand_loader: directed self-checking bench for crypto_operand_loader.
// Honours LOADER_BYTESWAP_EN when computing expected lane contents.
module tb_crypto_operand_loader;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          Master_clk;
  logic          Master_reset;
  logic          flush;
  logic [31:0]   word_in;
  logic          word_valid;
  logic          word_ready;
  logic [127:0]  blk_data;
  logic          blk_valid;
  logic          blk_ready;
  logic [CW-1:0] fifo_count;
  logic [1:0]    word_idx;

  int vecCount = 0;
  int errCount = 0;

  crypto_operand_loader #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .Master_clk  (Master_clk),
    .Master_reset(Master_reset),
    .flush       (flush),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .blk_data    (blk_data),
    .blk_valid   (blk_valid),
    .blk_ready   (blk_ready),
    .fifo_count  (fifo_count),
    .word_idx    (word_idx)
  );

  // 10 ns free-running clock
  initial Master_clk = 1'b0;
  always #5 Master_clk = ~Master_clk;

  // Expected lane contents of one host word in this build
  function automatic logic [31:0] lane(input logic [31:0] w);
`ifdef LOADER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [127:0] blk(input logic [31:0] w0, input logic [31:0] w1,
                                       input logic [31:0] w2, input logic [31:0] w3);
    return {lane(w3), lane(w2), lane(w1), lane(w0)};
  endfunction

  function automatic logic [31:0] pat(input int b, input int j);
    return 32'hA5000000 ^ (32'(b) << 12) ^ (32'(j) << 4) ^ 32'(b * 7 + j);
  endfunction

  // One clock with the given word presented; inputs change 1 ns after the edge
  task automatic stepWord(input logic v, input logic [31:0] w, input logic rdy);
    word_valid = v;
    word_in    = w;
    blk_ready  = rdy;
    @(posedge Master_clk);
    #1;
    word_valid = 1'b0;
    blk_ready  = 1'b0;
  endtask

  task automatic pushBlock(input int b);
    for (int j = 0; j < 4; j++) stepWord(1'b1, pat(b, j), 1'b0);
  endtask

  task automatic doFlush();
    flush = 1'b1;
    @(posedge Master_clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    Master_reset = 1'b0;
    #12;
    vecCount++;
    if (word_ready !== 1'b1) begin errCount++; $display("[TB] FAIL rst_word_ready got %b want 1", word_ready); end
    vecCount++;
    if (blk_valid !== 1'b0) begin errCount++; $display("[TB] FAIL rst_blk_valid got %b want 0", blk_valid); end
    vecCount++;
    if (fifo_count !== 3'd0) begin errCount++; $display("[TB] FAIL rst_count got %0d want 0", fifo_count); end
    vecCount++;
    if (word_idx !== 2'd0) begin errCount++; $display("[TB] FAIL rst_word_idx got %0d want 0", word_idx); end
    @(negedge Master_clk);
    Master_reset = 1'b1;
    @(posedge Master_clk);
    #1;
  endtask

  task automatic test_single_block();
    logic [127:0] exp;
    stepWord(1'b1, 32'h03020100, 1'b0);
    stepWord(1'b1, 32'h07060504, 1'b0);
    vecCount++;
    if (word_idx !== 2'd2) begin errCount++; $display("[TB] FAIL single_idx got %0d want 2", word_idx); end
    stepWord(1'b1, 32'h0B0A0908, 1'b0);
    vecCount++;
    if (blk_valid !== 1'b0) begin errCount++; $display("[TB] FAIL single_early_valid got %b want 0", blk_valid); end
    stepWord(1'b1, 32'h0F0E0D0C, 1'b0);
`ifdef LOADER_BYTESWAP_EN
    exp = 128'h0C0D0E0F08090A0B0405060700010203;
`else
    exp = 128'h0F0E0D0C0B0A09080706050403020100;
`endif
    vecCount++;
    if (blk_valid !== 1'b1) begin errCount++; $display("[TB] FAIL single_valid got %b want 1", blk_valid); end
    vecCount++;
    if (blk_data !== exp) begin errCount++; $display("[TB] FAIL single_data got %h want %h", blk_data, exp); end
    vecCount++;
    if (fifo_count !== 3'd1) begin errCount++; $display("[TB] FAIL single_count got %0d want 1", fifo_count); end
    vecCount++;
    if (word_idx !== 2'd0) begin errCount++; $display("[TB] FAIL single_idx_wrap got %0d want 0", word_idx); end
    // hold off a few cycles: head must be stable
    repeat (3) stepWord(1'b0, 32'h0, 1'b0);
    vecCount++;
    if (blk_data !== exp) begin errCount++; $display("[TB] FAIL single_hold got %h want %h", blk_data, exp); end
    stepWord(1'b0, 32'h0, 1'b1);
    vecCount++;
    if (blk_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errCount++; $display("[TB] FAIL single_pop valid %b count %0d want 0 0", blk_valid, fifo_count);
    end
    // pop while empty is ignored
    stepWord(1'b0, 32'h0, 1'b1);
    vecCount++;
    if (fifo_count !== 3'd0) begin errCount++; $display("[TB] FAIL empty_pop count %0d want 0", fifo_count); end
  endtask

  task automatic test_fill_full();
    logic [127:0] exp;
    for (int b = 0; b < 4; b++) pushBlock(b);
    vecCount++;
    if (fifo_count !== 3'd4) begin errCount++; $display("[TB] FAIL full_count got %0d want 4", fifo_count); end
    vecCount++;
    if (word_ready !== 1'b0) begin errCount++; $display("[TB] FAIL full_ready got %b want 0", word_ready); end
    repeat (3) stepWord(1'b1, 32'hDEADBEEF, 1'b0);
    vecCount++;
    if (word_idx !== 2'd0 || fifo_count !== 3'd4) begin
      errCount++; $display("[TB] FAIL full_reject idx %0d count %0d want 0 4", word_idx, fifo_count);
    end
    exp = blk(pat(0, 0), pat(0, 1), pat(0, 2), pat(0, 3));
    vecCount++;
    if (blk_data !== exp) begin errCount++; $display("[TB] FAIL full_head got %h want %h", blk_data, exp); end
    stepWord(1'b0, 32'h0, 1'b1);
    vecCount++;
    if (word_ready !== 1'b1 || fifo_count !== 3'd3) begin
      errCount++; $display("[TB] FAIL full_pop ready %b count %0d want 1 3", word_ready, fifo_count);
    end
    exp = blk(pat(1, 0), pat(1, 1), pat(1, 2), pat(1, 3));
    vecCount++;
    if (blk_data !== exp) begin errCount++; $display("[TB] FAIL full_next_head got %h want %h", blk_data, exp); end
    doFlush();
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp;
    pushBlock(20);
    pushBlock(21);
    for (int j = 0; j < 3; j++) stepWord(1'b1, pat(22, j), 1'b0);
    stepWord(1'b1, pat(22, 3), 1'b1);
    vecCount++;
    if (fifo_count !== 3'd2) begin errCount++; $display("[TB] FAIL pushpop_count got %0d want 2", fifo_count); end
    exp = blk(pat(21, 0), pat(21, 1), pat(21, 2), pat(21, 3));
    vecCount++;
    if (blk_data !== exp) begin errCount++; $display("[TB] FAIL pushpop_head got %h want %h", blk_data, exp); end
    stepWord(1'b0, 32'h0, 1'b1);
    exp = blk(pat(22, 0), pat(22, 1), pat(22, 2), pat(22, 3));
    vecCount++;
    if (blk_data !== exp) begin errCount++; $display("[TB] FAIL pushpop_tail got %h want %h", blk_data, exp); end
    doFlush();
  endtask

  task automatic test_wrap();
    logic [127:0] exp;
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < 3; j++) stepWord(1'b1, pat(40 + b, j), 1'b0);
      if (b > 0) begin
        exp = blk(pat(39 + b, 0), pat(39 + b, 1), pat(39 + b, 2), pat(39 + b, 3));
        vecCount++;
        if (blk_data !== exp) begin errCount++; $display("[TB] FAIL wrap_blk%0d got %h want %h", b - 1, blk_data, exp); end
      end
      stepWord(1'b1, pat(40 + b, 3), (b > 0) ? 1'b1 : 1'b0);
    end
    vecCount++;
    if (fifo_count !== 3'd1) begin errCount++; $display("[TB] FAIL wrap_count got %0d want 1", fifo_count); end
    exp = blk(pat(49, 0), pat(49, 1), pat(49, 2), pat(49, 3));
    vecCount++;
    if (blk_data !== exp) begin errCount++; $display("[TB] FAIL wrap_blk9 got %h want %h", blk_data, exp); end
    stepWord(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_flush();
    logic [127:0] exp;
    for (int b = 0; b < 3; b++) pushBlock(60 + b);
    stepWord(1'b1, pat(63, 0), 1'b0);
    stepWord(1'b1, pat(63, 1), 1'b0);
    flush = 1'b1;
    stepWord(1'b1, pat(63, 2), 1'b1);
    flush = 1'b0;
    vecCount++;
    if (fifo_count !== 3'd0 || word_idx !== 2'd0 || blk_valid !== 1'b0) begin
      errCount++; $display("[TB] FAIL flush_state count %0d idx %0d valid %b want 0 0 0", fifo_count, word_idx, blk_valid);
    end
    pushBlock(70);
    exp = blk(pat(70, 0), pat(70, 1), pat(70, 2), pat(70, 3));
    vecCount++;
    if (blk_data !== exp || fifo_count !== 3'd1) begin
      errCount++; $display("[TB] FAIL flush_reassemble got %h count %0d want %h 1", blk_data, fifo_count, exp);
    end
    stepWord(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_async_reset();
    logic [31:0] exp;
    pushBlock(80);
    stepWord(1'b1, pat(81, 0), 1'b0);
    stepWord(1'b1, pat(81, 1), 1'b0);
    #2;
    Master_reset = 1'b0;
    #1;
    vecCount++;
    if (word_idx !== 2'd0 || fifo_count !== 3'd0 || blk_valid !== 1'b0 || word_ready !== 1'b1) begin
      errCount++; $display("[TB] FAIL async_reset idx %0d count %0d valid %b ready %b want 0 0 0 1",
                           word_idx, fifo_count, blk_valid, word_ready);
    end
    @(negedge Master_clk);
    Master_reset = 1'b1;
    @(posedge Master_clk);
    #1;
    stepWord(1'b1, 32'h11223344, 1'b0);
    stepWord(1'b1, 32'h55667788, 1'b0);
    stepWord(1'b1, 32'h99AABBCC, 1'b0);
    stepWord(1'b1, 32'hDDEEFF00, 1'b0);
`ifdef LOADER_BYTESWAP_EN
    exp = 32'h44332211;
`else
    exp = 32'h11223344;
`endif
    vecCount++;
    if (blk_data[31:0] !== exp || fifo_count !== 3'd1) begin
      errCount++; $display("[TB] FAIL byteswap_lane0 got %h count %0d want %h 1", blk_data[31:0], fifo_count, exp);
    end
  endtask

  initial begin
    flush      = 1'b0;
    word_in    = 32'h0;
    word_valid = 1'b0;
    blk_ready  = 1'b0;
    test_reset();
    test_single_block();
    test_fill_full();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/crypto_operand_loader.md
# crypto_operand_loader

Upstream input stage for the crypto core. Accepts 32-bit words from the host bus, assembles four of them into a 128-bit operand and queues complete operands in a small block FIFO. Operands are presented to the core with a valid/ready handshake; the core's sequencer consumes one operand per handshake, in place of sampling a raw 128-bit bus. Decouples host write pacing from RSA/AES operation latency, so the host can stream several blocks while an operation is still running.

## Interface

**Parameters**
- `FIFO_DEPTH`, default 4: number of 128-bit operand slots. Must be a power of two, range 2 to 16.
- `CNT_W`, default $clog2(FIFO_DEPTH)+1: width of the occupancy count.

**Ports** (clock and reset first)
- `Master_clk`, input, 1: the single clock; everything is rising-edge.
- `Master_reset`, input, 1: asynchronous, active-low reset. Assertion clears all state immediately. Release is synchronised externally.
- `flush`, input, 1: synchronous clear of the FIFO and of any partially assembled operand.
- `word_in`, input, 32: host data word.
- `word_valid`, input, 1: `word_in` is valid this cycle.
- `word_ready`, output, 1: the loader can accept a word this cycle.
- `blk_data`, output, 128: operand at the FIFO head.
- `blk_valid`, output, 1: `blk_data` holds a complete operand.
- `blk_ready`, input, 1: the core consumes the head operand this cycle.
- `fifo_count`, output, `CNT_W`: number of complete operands stored.
- `word_idx`, output, 2: number of words already held in the assembler (0 to 3).

## Operation

**Word accept**
- A word is accepted on any rising edge where `word_valid && word_ready`.
- `word_ready = (fifo_count != FIFO_DEPTH)`. It is a registered-state decode only, with no combinational path from `blk_ready`.
- Words arrive least-significant first:
  - word 0 goes to bits [31:0];
  - word 1 to [63:32];
  - word 2 to [95:64];
  - word 3 to [127:96].

**Assembler**
- A 2-bit counter, `word_idx`, forms an implicit four-state FSM: W0 → W1 → W2 → W3 → W0, advancing on each accept.
- On the accept made in W3, the complete 128-bit operand (three held words plus the current `word_in`) is written into the FIFO tail on that same edge.
- `word_idx` then returns to 0.
- The assembler register is not cleared between blocks, but stale upper words are never pushed.

**FIFO**
- Circular buffer with read and write pointers of width log2(`FIFO_DEPTH`) that wrap modulo `FIFO_DEPTH`.
- `blk_data` is the array entry at the read pointer; no extra output register.
- Pop happens on `blk_valid && blk_ready`: the read pointer advances.
- `blk_valid = (fifo_count != 0)`.

**Counter rules**
- Push only: count + 1.
- Pop only: count − 1.
- Push and pop in the same cycle: count unchanged, both pointers advance. This is legal at count == `FIFO_DEPTH` only if no push occurs; `word_ready` already prevents that push.
- Pop while empty is ignored, since `blk_valid` is 0.

**Flush**
- `flush` has priority over push, pop and word accept in the same cycle.
- Pointers, count and `word_idx` go to 0, and a word presented that cycle is discarded.

**Reset**
- Asynchronous; forces the same state as flush.
- The FIFO storage array is not reset, so `blk_data` is don't-care while `blk_valid` = 0.

## Timing

**Reset values**
- `word_ready` = 1
- `blk_valid` = 0
- `fifo_count` = 0
- `word_idx` = 0
- `blk_data` = X (don't-care)

**Latency and throughput**
- Latency from the accept of word 3 to `blk_valid` high is 1 cycle when the FIFO was empty.
- The core can pop a block in the cycle after it is pushed.
- Full throughput is one word per cycle, i.e. one operand per 4 cycles.

**Full boundary**
- When count reaches `FIFO_DEPTH`, `word_ready` drops on the next cycle.
- A pop at full restores `word_ready` one cycle later.

**Mid-operation events**
- Reset asserted mid-block: partial words are lost, and assembly restarts at W0 after release.
- `blk_data` is stable while `blk_valid && !blk_ready`. The core may hold off for any number of cycles.

## Configuration

- Macro: `LOADER_BYTESWAP_EN`.
- Defined: each accepted word is byte-reversed before storage (`word_in[7:0]` lands in bits [31:24] of its lane). This supports big-endian hosts.
- Undefined: words are stored unmodified.
- Ordering, handshake and timing are identical in both builds.

## Test plan

1. **Single block.** After reset, write 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive cycles with `blk_ready` = 0.
   - Required: `blk_valid` = 1 one cycle after the last accept.
   - `blk_data` = 0x0F0E0D0C0B0A09080706050403020100, `fifo_count` = 1.
2. **Fill to full.** Stream 16 words with `blk_ready` = 0, `FIFO_DEPTH` = 4.
   - Required: `fifo_count` = 4 and `word_ready` = 0; a 17th word held valid is not accepted and `word_idx` stays 0.
   - One pop restores `word_ready` one cycle later.
3. **Simultaneous push and pop.** With count = 2, complete a block on the same edge as a pop.
   - Required: count stays 2, and the head advances to the older block in FIFO order.
4. **Pointer wrap.** Push and pop 10 blocks with distinct patterns through depth 4.
   - Required: the output order matches the input order exactly across the pointer wrap.
5. **Flush priority.** Hold `flush` = 1 together with a valid word and `blk_ready` at `word_idx` = 2, count = 3.
   - Required: next cycle count = 0, `word_idx` = 0, `blk_valid` = 0.
   - A subsequent 4-word block is assembled correctly from W0.
6. **Async reset and byteswap.** Assert `Master_reset` = 0 mid-cycle after 2 words have been written.
   - Required: outputs reach their reset values without waiting for a clock edge.
   - With `LOADER_BYTESWAP_EN` defined, word 0x11223344 appears as 0x44332211 in bits [31:0].
